// File: rtl/alu_disp_pkg.sv
// ---------------------------------------------------------------------------
// alu_disp_pkg
// Shared definitions for the ALU result display path: converter FSM state
// encoding, bus widths and the active-low 7-segment glyph table.
// ---------------------------------------------------------------------------
package alu_disp_pkg;

  localparam int BIN_W   = 16;           // binary input width
  localparam int NUM_BCD = 5;            // BCD digits needed for 65535
  localparam int BCD_W   = 4 * NUM_BCD;  // packed BCD width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Double-dabble correction: add 3 to every nibble that is 5 or more so the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < NUM_BCD; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: one adjust+shift iteration per clock.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   start     in   request a conversion (honoured only while idle)
//   bin_in    in   [15:0] binary value, captured on the accepting edge
//   idle      out  converter is in IDLE and will accept start
//   busy      out  conversion in progress
//   bcd_valid out  bcd_out holds a completed result (sticky)
//   bcd_out   out  [19:0] five BCD nibbles, [19:16] = ten-thousands
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import alu_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             idle,
  output logic             busy,
  output logic             bcd_valid,
  output logic [BCD_W-1:0] bcd_out
);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] shreg;
  logic [BCD_W-1:0] scratch;
  logic [4:0]       count;

  assign idle = (state_q == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: default assignment first so no path leaves state_d unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (count == 5'(BIN_W - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath. bcd_out is only written in DONE, so it keeps the previous
  // result for the whole duration of a new conversion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      scratch   <= '0;
      count     <= '0;
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
      bcd_out   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shreg   <= bin_in;
            scratch <= '0;
            count   <= '0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= {dabble_adjust(scratch), shreg} << 1;
          count            <= count + 5'd1;
        end
        DONE: begin
          bcd_out   <= scratch;
          bcd_valid <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_bcd_display.sv
// ---------------------------------------------------------------------------
// alu_bcd_display
// Shows the ALU 16-bit result on a 4-digit multiplexed common-anode display.
// Re-converts whenever bin_in differs from the last converted value.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   bin_in    in   [15:0] binary value to display
//   flag_in   in   ALU flag, shown on the leftmost decimal point
//   busy      out  conversion in progress
//   bcd_valid out  bcd_out holds a completed conversion
//   bcd_out   out  [19:0] BCD result, [19:16] = ten-thousands
//   an        out  [3:0] digit enables, active-low, an[0] = rightmost
//   seg       out  [6:0] segments, active-low, {g,f,e,d,c,b,a}
//   dp        out  decimal point, active-low
// ---------------------------------------------------------------------------
module alu_bcd_display
  import alu_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  flag_in,
  output logic                  busy,
  output logic                  bcd_valid,
  output logic [BCD_W-1:0]      bcd_out,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DISP_W = 4 * NUM_DIGITS;

  // ---------------- change detector ----------------
  logic [BIN_W-1:0] last_bin;
  logic             init_pending;
  logic             conv_idle;
  logic             start;

  // init_pending forces one conversion after reset even if bin_in is 0.
  assign start = init_pending || (bin_in != last_bin);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_bin     <= '0;
      init_pending <= 1'b1;
    end else if (start && conv_idle) begin
      last_bin     <= bin_in;
      init_pending <= 1'b0;
    end
  end

  bin2bcd_seq u_conv (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bin_in    (bin_in),
    .idle      (conv_idle),
    .busy      (busy),
    .bcd_valid (bcd_valid),
    .bcd_out   (bcd_out)
  );

  // ---------------- scan timing ----------------
  logic [PRE_W-1:0] prescaler;
  logic [IDX_W-1:0] digit_idx;
  logic             flag_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      digit_idx <= '0;
      flag_q    <= 1'b0;
    end else begin
      flag_q <= flag_in;
      if (prescaler == PRE_W'(REFRESH_DIV - 1)) begin
        prescaler <= '0;
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // ---------------- segment decode ----------------
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [3:0]            nibble;
  logic [DISP_W-1:0]     upper;
  logic                  overflow;

  always_comb begin
    an_d     = '1;
    seg_d    = SEG_BLANK;
    dp_d     = 1'b1;
    nibble   = bcd_out[{digit_idx, 2'b00} +: 4];
    // Nonzero iff this digit or any digit above it is nonzero.
    upper    = bcd_out[DISP_W-1:0] >> {digit_idx, 2'b00};
    overflow = (bcd_out[BCD_W-1:DISP_W] != '0);

    if (bcd_valid) begin
      an_d = ~(NUM_DIGITS'(1) << digit_idx);
      if (overflow)                               seg_d = SEG_DASH;
      else if (digit_idx != '0 && upper == '0)    seg_d = SEG_BLANK;
      else if (nibble <= 4'd9)                    seg_d = SEG_DIGIT[nibble];
      else                                        seg_d = SEG_BLANK;
    end

    if (digit_idx == IDX_W'(NUM_DIGITS - 1)) dp_d = ~flag_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule
